// File: rtl/tri_step_sweep.sv
// Sweeps the triangle generator's step word from start to stop, holding each value for max(dwell,1) cycles.
// First value appears one cycle after start; cfg_ready is high only while idle, so config is refused mid-sweep.
module tri_step_sweep #(
  parameter int DWELL_W = 32,
  parameter int STEP_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [STEP_W-1:0]  cfg_start,
  input  logic [STEP_W-1:0]  cfg_stop,
  input  logic [STEP_W-1:0]  cfg_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               start,
  input  logic               abort,
  output logic [STEP_W-1:0]  step,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [DWELL_W-1:0] ONE_D = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [0:0]         state;
  logic [STEP_W-1:0]  start_q, stop_q, inc_q;
  logic [DWELL_W-1:0] dwell_q, cnt;
  logic               loop_q, down_q;

  logic               cfg_fire;
  logic [STEP_W-1:0]  eff_start;
  logic [DWELL_W-1:0] eff_dwell, eff_reload, reload_q;
  logic [STEP_W:0]    up_sum, dn_diff;
  logic [STEP_W-1:0]  next_step;
  logic               at_stop;

  assign cfg_ready = (state == IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready;

  // A config handshake in the same cycle as start takes effect for this sweep.
  assign eff_start  = cfg_fire ? cfg_start : start_q;
  assign eff_dwell  = cfg_fire ? cfg_dwell : dwell_q;
  assign eff_reload = (eff_dwell == '0) ? '0 : eff_dwell - ONE_D;
  assign reload_q   = (dwell_q == '0) ? '0 : dwell_q - ONE_D;

  // One extra bit catches carry on the way up and borrow on the way down.
  assign up_sum  = {1'b0, step} + {1'b0, inc_q};
  assign dn_diff = {1'b0, step} - {1'b0, inc_q};
  assign at_stop = (step == stop_q);

  always_comb begin
    next_step = stop_q;
    if (inc_q != '0) begin
      if (down_q) begin
        if (!dn_diff[STEP_W] && (dn_diff[STEP_W-1:0] > stop_q))
          next_step = dn_diff[STEP_W-1:0];
      end else begin
        if (!up_sum[STEP_W] && (up_sum[STEP_W-1:0] < stop_q))
          next_step = up_sum[STEP_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      dwell_q <= '0;
      loop_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_fire) begin
        start_q <= cfg_start;
        stop_q  <= cfg_stop;
        inc_q   <= cfg_inc;
        dwell_q <= cfg_dwell;
        loop_q  <= cfg_loop;
        down_q  <= (cfg_start > cfg_stop);
      end
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= RUN;
            busy  <= 1'b1;
            step  <= eff_start;
            cnt   <= eff_reload;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE_D;
          end else begin
            cnt <= reload_q;
            if (at_stop) begin
              if (loop_q) begin
                step <= start_q;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              step <= next_step;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_step_sweep.sv
// Bench for tri_step_sweep: directed corner cases plus randomized sweeps checked against a value-list model.
module tb_tri_step_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start, cfg_stop, cfg_inc, cfg_dwell;
  logic        cfg_loop;
  logic        start, abort;
  logic [31:0] step;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_vals[$];

  tri_step_sweep #(.DWELL_W(32), .STEP_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_inc(cfg_inc),
    .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
    .start(start), .abort(abort),
    .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] s, input logic b, input logic d);
    check({tag, ".step"}, step, s);
    check({tag, ".busy"}, busy, b);
    check({tag, ".done"}, done, d);
    check({tag, ".cfg_ready"}, cfg_ready, !b);
  endtask

  // Ordered list of distinct values the sweep visits, from the rules in plain wide arithmetic.
  task automatic build_seq(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc);
    logic [31:0] v;
    longint nx;
    exp_vals.delete();
    v = s;
    exp_vals.push_back(v);
    while (v != e && exp_vals.size() < 2000) begin
      if (inc == 0) v = e;
      else if (s <= e) begin
        nx = longint'(v) + longint'(inc);
        v = (nx >= longint'(e)) ? e : nx[31:0];
      end else begin
        nx = longint'(v) - longint'(inc);
        v = (nx <= longint'(e)) ? e : nx[31:0];
      end
      exp_vals.push_back(v);
    end
  endtask

  task automatic drive_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                           input logic [31:0] dw, input logic lp);
    cfg_start = s; cfg_stop = e; cfg_inc = inc; cfg_dwell = dw; cfg_loop = lp;
  endtask

  // mode 0: config then start, 1: config with start, 2: start with already-latched config
  task automatic run_single(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                            input logic [31:0] dw, input int mode, input int abort_at,
                            input bit poke, input string tag);
    int dwe, total;
    dwe = (dw == 0) ? 1 : int'(dw);
    build_seq(s, e, inc);
    total = exp_vals.size() * dwe;
    if (mode == 0) begin
      drive_cfg(s, e, inc, dw, 1'b0);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      drive_cfg($urandom, $urandom, $urandom, $urandom, 1'b1);
      check({tag, ".cfg_idle"}, busy, 1'b0);
      start = 1'b1;
    end else if (mode == 1) begin
      drive_cfg(s, e, inc, dw, 1'b0);
      cfg_valid = 1'b1;
      start = 1'b1;
    end else begin
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    cfg_valid = 1'b0;
    for (int c = 0; c < total; c++) begin
      check_out(tag, exp_vals[c / dwe], 1'b1, 1'b0);
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_out({tag, ".abort"}, exp_vals[c / dwe], 1'b0, 1'b0);
        return;
      end
      if (poke && c == 1) begin
        start = 1'b1;
        cfg_valid = 1'b1;
        drive_cfg($urandom, $urandom, $urandom, 32'd0, 1'b1);
      end else begin
        start = 1'b0;
        cfg_valid = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    check_out({tag, ".done"}, e, 1'b0, 1'b1);
    @(negedge clk);
    check_out({tag, ".after"}, e, 1'b0, 1'b0);
  endtask

  task automatic run_loop(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                          input logic [31:0] dw, input int ncyc, input string tag);
    int dwe;
    logic [31:0] held;
    dwe = (dw == 0) ? 1 : int'(dw);
    build_seq(s, e, inc);
    drive_cfg(s, e, inc, dw, 1'b1);
    cfg_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    held = exp_vals[0];
    for (int c = 0; c < ncyc; c++) begin
      held = exp_vals[(c / dwe) % exp_vals.size()];
      check_out(tag, held, 1'b1, 1'b0);
      if (c != ncyc - 1) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_out({tag, ".abort"}, held, 1'b0, 1'b0);
    @(negedge clk);
    check_out({tag, ".hold"}, held, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] s, e, inc, dw;
    int span, r;
    rst_n = 1'b0;
    cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    drive_cfg(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    #12;
    check_out("reset", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_out("post_reset", 32'd0, 1'b0, 1'b0);

    run_single(32'd100, 32'd130, 32'd10, 32'd3, 0, -1, 1'b0, "up_sweep");
    run_single(32'd0, 32'd25, 32'd10, 32'd1, 1, -1, 1'b0, "sat_up");
    run_single(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 32'd1, 1, -1, 1'b0, "carry_clamp");
    run_single(32'd1000, 32'd990, 32'd4, 32'd2, 1, -1, 1'b0, "down_sweep");
    run_single(32'd1000, 32'd0, 32'd600, 32'd1, 0, -1, 1'b0, "borrow_clamp");
    run_single(32'd50, 32'd90, 32'd0, 32'd2, 1, -1, 1'b0, "inc_zero");
    run_single(32'd77, 32'd77, 32'd5, 32'd3, 1, -1, 1'b0, "start_eq_stop");
    run_single(32'd10, 32'd40, 32'd10, 32'd0, 1, -1, 1'b1, "dwell_zero_poke");
    run_single(32'd100, 32'd130, 32'd10, 32'd2, 1, 7, 1'b0, "abort_at_end");
    run_loop(32'd0, 32'd20, 32'd10, 32'd1, 5, "loop_abort");

    // abort beats start while idle; step keeps the aborted value
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_out("idle_abort_start", 32'd10, 1'b0, 1'b0);
    @(negedge clk);
    check_out("idle_abort_start2", 32'd10, 1'b0, 1'b0);

    // asynchronous reset between edges during a sweep
    drive_cfg(32'd500, 32'd600, 32'd1, 32'd5, 1'b0);
    cfg_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    check_out("pre_rst", 32'd500, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_single(32'd0, 32'd0, 32'd0, 32'd0, 2, -1, 1'b0, "rst_cfg_zero");

    for (int it = 0; it < 25; it++) begin
      span = $urandom_range(0, 120);
      s = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (s > 32'hFFFF_FF00) s = s - 32'h200;
        e = s + span;
      end else begin
        if (s < 32'h200) s = s + 32'h200;
        e = s - span;
      end
      r = $urandom_range(0, 9);
      if (r == 0) inc = 32'd0;
      else if (r == 1) inc = $urandom;
      else inc = $urandom_range(1, 40);
      dw = $urandom_range(0, 3);
      if (it % 5 == 4 && s != e && inc != 0)
        run_loop(s, e, inc, dw, $urandom_range(3, 30), "rnd_loop");
      else
        run_single(s, e, inc, dw, $urandom_range(0, 1), -1, 1'($urandom_range(0, 1)), "rnd_single");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tri_step_sweep.md
Name: tri_step_sweep

Overview:
- Upstream control stage for the triangle generator. Produces the 32-bit `step` word that the generator's phase accumulator consumes.
- Sweeps `step` linearly from a start value to a stop value, in increments of `inc_step`. Each value is held for a programmable dwell time.
- Supports single-shot and continuous-loop sweeps.
- Configuration arrives over a valid/ready handshake from the PS-side register block.

Parameters:
- DWELL_W, 32, width of the dwell counter and of the `dwell` config field.
- STEP_W, 32, width of all step values; must equal the generator's step input width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- cfg_valid  in  1  configuration word valid.
- cfg_ready  out  1  block accepts config (high only in IDLE).
- cfg_start  in  STEP_W  first step value of the sweep.
- cfg_stop  in  STEP_W  last step value of the sweep.
- cfg_inc  in  STEP_W  increment magnitude per dwell period.
- cfg_dwell  in  DWELL_W  cycles each value is held (0 treated as 1).
- cfg_loop  in  1  1 = restart at start after stop, 0 = single shot.
- start  in  1  single-cycle request to begin a sweep.
- abort  in  1  single-cycle request to end the sweep immediately.
- step  out  STEP_W  registered step word to the triangle generator.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a single-shot sweep completes.

Behaviour:
- Reset values:
  - step = 0, busy = 0, done = 0, cfg_ready = 1.
  - All config registers = 0; dwell counter = 0; state = IDLE.
  - Reset asserted mid-sweep takes effect immediately (asynchronously) with these same values.
- Config capture: on a rising edge with cfg_valid && cfg_ready, all cfg_* fields are latched. cfg_valid is ignored outside IDLE.
- Direction is fixed at capture: down = (cfg_start > cfg_stop), unsigned compare.
- States:
  - IDLE:
    - start -> RUN. At the next edge step = latched start, busy = 1, dwell counter = max(dwell,1) - 1.
    - If cfg handshake and start occur in the same cycle, the newly presented config is used.
  - RUN:
    - The dwell counter decrements each cycle. At zero, the step update below occurs and the counter reloads.
    - Every step value is therefore visible for exactly max(dwell,1) cycles.
    - Step update:
      - If step == stop and loop = 0: go to IDLE; done = 1 for one cycle; busy = 0 on the same edge; step holds stop.
      - If step == stop and loop = 1: step = start. No done pulse.
      - Otherwise, up sweep: next = step + inc, computed STEP_W+1 bits wide. If the carry is set or next >= stop, step = stop.
      - Otherwise, down sweep: next = step - inc, with borrow detection. If a borrow occurs or next <= stop, step = stop.
      - inc = 0: the first update jumps straight to stop.
      - start == stop: the value is held for one dwell, then the step == stop rules apply.
- abort:
  - In RUN: go to IDLE next edge, busy = 0, step holds its current value, no done pulse. Abort wins over a same-cycle completion.
  - In IDLE: abort wins over start; the block stays in IDLE.
- start while in RUN is ignored.
- done is never asserted in loop mode. done never coincides with busy = 1.
- Latency:
  - start to first step value: 1 cycle.
  - Final stop value to done: max(dwell,1) cycles after stop first appears.
  - The generator applies its own 1-cycle step register after this block.

Test Plan:
1. Single up sweep. cfg start=100, stop=130, inc=10, dwell=3, loop=0; start at cycle T -> step is 100 for T+1..T+3, 110 for T+4..T+6, 120 for T+7..T+9, 130 for T+10..T+12. done=1 only at T+13 with busy=0; step stays 130.
2. Saturation and wrap. (a) start=0, stop=25, inc=10, dwell=1 -> step 0, 10, 20, 25, then done. (b) start=0xFFFFFFF0, stop=0xFFFFFFFF, inc=0x20 -> step 0xFFFFFFF0, 0xFFFFFFFF (carry clamps, no wrap to 0x10), then done.
3. Down sweep. start=1000, stop=990, inc=4, dwell=2 -> each of 1000, 996, 992, 990 held 2 cycles, then done. Repeat with stop=0, inc=600, start=1000 -> 1000, 400, 0 (borrow clamps).
4. Loop and abort. start=0, stop=20, inc=10, dwell=1, loop=1 -> 0, 10, 20, 0, 10, ... with no done. Pulse abort while step=10 -> next edge busy=0, step holds 10, cfg_ready=1, no done.
5. Simultaneous events. cfg_valid with start in the same IDLE cycle -> the new cfg_start appears at T+1. start during RUN -> no effect. abort together with start in IDLE -> stays IDLE. dwell=0 -> behaves as dwell=1.
6. Reset mid-sweep. Assert rst_n=0 asynchronously between clock edges during RUN -> step=0, busy=0, done=0, cfg_ready=1 immediately. A subsequent start without a new cfg -> step 0 for 1 cycle, then done.
